gcm_decrypt_verify: RTL

Single-block AES-GCM decryption and tag-verification engine: the receive-side counterpart of the `gcm_aes` encrypt/tag path. It accepts one AAD block, one ciphertext block and a received 128-bit tag. It computes GHASH with a bit-serial GF(2^128) multiplier and forms the expected tag. It releases the plaintext only when the tag matches. AES block-cipher outputs (H, E_K(J0), keystream) come precomputed from the shared AES core, so this block contains no cipher rounds.

---
 rtl/gcm_decrypt_verify.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gcm_decrypt_verify.sv
// Single-block AES-GCM decrypt + tag verify.
// GHASH over (A, C, L) with a bit-serial GF(2^128) multiplier, one bit per
// cycle. Plaintext is released only when the computed tag matches i_tag.
// Bit 0 of every [0:127] vector is the MSB (SP 800-38D ordering).
module gcm_decrypt_verify (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [0:127] i_hash_key,
    input  logic [0:127] i_ek_j0,
    input  logic [0:127] i_keystream,
    input  logic [0:127] i_aad,
    input  logic [7:0]   i_aad_len,
    input  logic [0:127] i_cipher_text,
    input  logic [7:0]   i_ct_len,
    input  logic [0:127] i_tag,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tag_ok,
    output logic         o_error,
    output logic [0:127] o_plain_text,
    output logic [0:127] o_tag
);

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_C, MUL_L, FINAL, DONE} state_t;

    // Reduction constant for the right shift: x^128 = x^7 + x^2 + x + 1
    localparam logic [0:127] R_POLY = {8'he1, 120'b0};
    localparam logic [0:127] ONES   = '1;

    // Keep the first len bits (MSB side), zero the rest
    function automatic logic [0:127] len_mask(input logic [7:0] len);
        return ~(ONES >> len);
    endfunction

    function automatic logic is_mul(input state_t s);
        return (s == MUL_A) || (s == MUL_C) || (s == MUL_L);
    endfunction

    state_t       state, state_n;
    logic         accept, load, bad_len;

    // Request registers (captured on accept)
    logic [0:127] h_r, ekj0_r, ks_r, aad_r, ct_r, tag_r;
    logic [7:0]   aad_len_r, ct_len_r;
    logic         err_r;

    // GHASH / multiplier state
    logic [0:127] y, z, v, x;
    logic [6:0]   cnt;

    logic [0:127] z_step, v_step;
    logic [0:127] a_src, c_src, l_src, h_src, y_src, next_blk;
    logic [0:127] tag_calc, pt_calc;
    logic         tag_match;

    assign accept  = i_start && ((state == IDLE) || (state == DONE));
    assign bad_len = (i_aad_len > 8'd128) || (i_ct_len > 8'd128);
    assign o_busy  = is_mul(state) || (state == FINAL);
    assign o_done  = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_n;
    end

    // Next-state: skip empty A/C blocks, error requests go straight through FINAL
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (accept) begin
                    if (bad_len)               state_n = FINAL;
                    else if (i_aad_len != '0)  state_n = MUL_A;
                    else if (i_ct_len != '0)   state_n = MUL_C;
                    else                       state_n = MUL_L;
                end
            end
            MUL_A: if (cnt == 7'd127) state_n = (ct_len_r != '0) ? MUL_C : MUL_L;
            MUL_C: if (cnt == 7'd127) state_n = MUL_L;
            MUL_L: if (cnt == 7'd127) state_n = FINAL;
            FINAL: state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Multiplier step and operand selection for the next block load
    always_comb begin
        z_step   = x[0] ? (z ^ v) : z;
        v_step   = (v >> 1) ^ (v[127] ? R_POLY : '0);
        // On accept the block operands come straight from the inputs being captured
        a_src    = accept ? (i_aad & len_mask(i_aad_len)) : aad_r;
        c_src    = accept ? (i_cipher_text & len_mask(i_ct_len)) : ct_r;
        l_src    = accept ? {56'b0, i_aad_len, 56'b0, i_ct_len}
                          : {56'b0, aad_len_r, 56'b0, ct_len_r};
        h_src    = accept ? i_hash_key : h_r;
        y_src    = accept ? '0 : z_step;
        case (state_n)
            MUL_A:   next_blk = a_src;
            MUL_C:   next_blk = c_src;
            default: next_blk = l_src;
        endcase
        load     = is_mul(state_n) && (state_n != state);
        tag_calc = y ^ ekj0_r;
        tag_match = (tag_calc == tag_r);
        pt_calc  = (ct_r ^ ks_r) & len_mask(ct_len_r);
    end

    // Request capture and GHASH datapath
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_r <= '0; ekj0_r <= '0; ks_r <= '0; aad_r <= '0; ct_r <= '0; tag_r <= '0;
            aad_len_r <= '0; ct_len_r <= '0; err_r <= 1'b0;
            y <= '0; z <= '0; v <= '0; x <= '0; cnt <= '0;
        end else begin
            if (is_mul(state)) begin
                z   <= z_step;
                v   <= v_step;
                x   <= x << 1;
                cnt <= cnt + 7'd1;
                if (cnt == 7'd127) y <= z_step;
            end
            // Entering a multiply: X = Y ^ block, Z = 0, V = H
            if (load) begin
                x   <= y_src ^ next_blk;
                z   <= '0;
                v   <= h_src;
                cnt <= '0;
            end
            if (accept) begin
                h_r       <= i_hash_key;
                ekj0_r    <= i_ek_j0;
                ks_r      <= i_keystream;
                aad_r     <= i_aad & len_mask(i_aad_len);
                ct_r      <= i_cipher_text & len_mask(i_ct_len);
                tag_r     <= i_tag;
                aad_len_r <= i_aad_len;
                ct_len_r  <= i_ct_len;
                err_r     <= bad_len;
                y         <= '0;
                cnt       <= '0;
            end
        end
    end

    // Result registers: cleared on a new request, loaded at the end of FINAL
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_tag_ok <= 1'b0; o_error <= 1'b0; o_plain_text <= '0; o_tag <= '0;
        end else if (accept) begin
            o_tag_ok <= 1'b0; o_error <= 1'b0; o_plain_text <= '0; o_tag <= '0;
        end else if (state == FINAL) begin
            o_error      <= err_r;
            o_tag_ok     <= !err_r && tag_match;
            o_tag        <= err_r ? '0 : tag_calc;
            o_plain_text <= (!err_r && tag_match) ? pt_calc : '0;
        end
    end

endmodule
